// File: rtl/mult_acc_seq.sv
// Sequential shift-and-add multiplier with HI:LO accumulator.
// One multiplier bit is consumed per cycle (LSB first), so every operation
// takes WIDTH+1 cycles from accept to result regardless of operand values.
// Signed operations multiply magnitudes and fix the sign in the final cycle.

module mult_acc_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic               clr,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic [2*WIDTH-1:0] dataOut,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] mcnd_q, mcnd_d;
    logic [WIDTH-1:0]   mpy_q, mpy_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   magA, magB;
    logic [2*WIDTH-1:0] prodSigned;

    // Operand magnitudes at accept time and the sign-corrected product at FIN;
    // the most negative value negates onto itself, which is its correct unsigned magnitude.
    always_comb begin
        magA       = (op[0] && dataA[WIDTH-1]) ? -dataA : dataA;
        magB       = (op[0] && dataB[WIDTH-1]) ? -dataB : dataB;
        prodSigned = neg_q ? -prod_q : prod_q;
    end

    // Next-state logic: accept/clear in IDLE, one shift-add step per CALC cycle, write-back in FIN.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        mcnd_d  = mcnd_q;
        mpy_d   = mpy_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (clr) begin
                    acc_d = '0;
                end else if (start) begin
                    op_d    = op;
                    neg_d   = op[0] & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                    mcnd_d  = {{WIDTH{1'b0}}, magA};
                    mpy_d   = magB;
                    prod_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (mpy_q[0]) begin
                    prod_d = prod_q + mcnd_q;
                end
                mcnd_d = mcnd_q << 1;
                mpy_d  = mpy_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                acc_d   = op_q[1] ? (acc_q + prodSigned) : prodSigned;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            mcnd_q  <= '0;
            mpy_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            mcnd_q  <= mcnd_d;
            mpy_q   <= mpy_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    assign dataOut = acc_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_mult_acc_seq.sv
// Self-checking bench for mult_acc_seq at WIDTH=32.
// A cycle-level behavioural model predicts dataOut/busy/done from plain
// arithmetic products; directed sequences add hand-computed expectations.

module tb_mult_acc_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     op;
    logic           clr;
    logic [W-1:0]   dataA;
    logic [W-1:0]   dataB;
    logic [2*W-1:0] dataOut;
    logic           busy;
    logic           done;

    int errCount   = 0;
    int checkCount = 0;
    int doneCount  = 0;
    bit checkEn    = 1'b0;

    logic [2*W-1:0] mOut;
    logic           mBusy;
    logic           mDone;
    int             mLeft;
    logic [2*W-1:0] mProd;
    logic           mAccum;

    mult_acc_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .clr     (clr),
        .dataA   (dataA),
        .dataB   (dataB),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                               input logic [2*W-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    function automatic logic [2*W-1:0] expectedProduct(input logic [1:0] o,
                                                       input logic [W-1:0] a,
                                                       input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        if (o[0]) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Behavioural model: an accepted operation finishes WIDTH+1 edges later.
    always @(posedge clk) begin
        if (reset === 1'b0) begin
            mBusy = 1'b0;
            mDone = 1'b0;
            mOut  = '0;
            mLeft = 0;
        end else if (mBusy) begin
            mDone = 1'b0;
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
                mBusy = 1'b0;
                mDone = 1'b1;
                mOut  = mAccum ? (mOut + mProd) : mProd;
            end
        end else begin
            mDone = 1'b0;
            if (clr) begin
                mOut = '0;
            end else if (start) begin
                mBusy  = 1'b1;
                mLeft  = W + 1;
                mProd  = expectedProduct(op, dataA, dataB);
                mAccum = op[1];
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_dataOut", dataOut, mOut);
            checkOutput("model_busy", 64'(busy), 64'(mBusy));
            checkOutput("model_done", 64'(done), 64'(mDone));
        end
    end

    // Counts done pulses so sequences can confirm exactly one per operation.
    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] o, input logic c,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        start = s;
        op    = o;
        clr   = c;
        dataA = a;
        dataB = b;
    endtask

    // Launch one operation and return in the cycle its done is high.
    task automatic runOp(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] expected);
        applyStimulus(1'b1, o, 1'b0, a, b);
        tick();
        applyStimulus(1'b0, o, 1'b0, a, b);
        repeat (W + 1) tick();
        checkOutput(name, dataOut, expected);
        checkOutput({name, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        int doneBefore;

        reset = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, '0, '0);
        repeat (3) tick();
        checkEn = 1'b1;
        checkOutput("reset_dataOut", dataOut, 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        reset = 1'b1;
        tick();

        runOp("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        runOp("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        runOp("mult_minxmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        runOp("mult_minx1", 2'b01, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);

        runOp("multu_2x3", 2'b00, 32'd2, 32'd3, 64'h6);
        runOp("maddu_4x5", 2'b10, 32'd4, 32'd5, 64'h1A);
        runOp("madd_m1x2", 2'b11, 32'hFFFF_FFFF, 32'd2, 64'h18);
        runOp("mult_m1x1", 2'b01, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        runOp("maddu_wrap", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0000);

        runOp("multu_0xdead", 2'b00, 32'd0, 32'hDEAD, 64'h0);
        runOp("maddu_5x0", 2'b10, 32'd5, 32'd0, 64'h0);

        runOp("multu_2x3_b", 2'b00, 32'd2, 32'd3, 64'h6);
        runOp("maddu_4x5_b", 2'b10, 32'd4, 32'd5, 64'h1A);
        applyStimulus(1'b1, 2'b00, 1'b1, 32'd9, 32'd9);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, '0, '0);
        checkOutput("clr_wins_dataOut", dataOut, 64'h0);
        checkOutput("clr_wins_busy", 64'(busy), 64'd0);
        tick();

        doneBefore = doneCount;
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd7, 32'd9);
        tick();
        for (int i = 1; i <= W + 1; i++) begin
            applyStimulus((i == 5) || (i == 20), 2'b11, (i == 10),
                          $urandom, $urandom);
            tick();
        end
        applyStimulus(1'b0, 2'b00, 1'b0, '0, '0);
        checkOutput("busy_start_ignored", dataOut, 64'h3F);
        repeat (3) tick();
        checkOutput("single_done", 64'(doneCount - doneBefore), 64'd1);

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h1234, 32'h10);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, '0, '0);
        repeat (10) tick();
        doneBefore = doneCount;
        reset = 1'b0;
        tick();
        checkOutput("abort_dataOut", dataOut, 64'h0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        repeat (W + 4) tick();
        checkOutput("abort_no_done", 64'(doneCount - doneBefore), 64'd0);
        runOp("multu_1x1", 2'b00, 32'd1, 32'd1, 64'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
